// File: rtl/mux_rr_arb_pkg.sv
// mux_pkg: shared channel-index width helper, wrap helper and index typedef for mux_rr_arb
package mux_pkg;
  localparam int N_INPUTS_DEF = 4;
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction
  typedef logic [sel_width(N_INPUTS_DEF)-1:0] ch_idx_t;
endpackage

// File: rtl/mux_rr_arb_if.sv
// mux_rr_arb_if: N-channel valid/ready input bus plus registered output stream (master=source/sink side, slave=mux side)
interface mux_rr_arb_if
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_INPUTS   = 4
);
  localparam int SEL_W = sel_width(N_INPUTS);
  logic [N_INPUTS*DATA_WIDTH-1:0] in_data;
  logic [N_INPUTS-1:0]            in_valid;
  logic [N_INPUTS-1:0]            in_ready;
  logic [DATA_WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]               out_sel;
  logic                           out_valid;
  logic                           out_ready;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_sel, out_valid);
  modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_sel, out_valid);
endinterface

// File: rtl/mux_rr_arb_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority arbiter; ports i_req, i_ptr in -> o_grant (one-hot), o_grant_idx, o_any_grant out
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_INPUTS = 4,
  localparam int SEL_W   = sel_width(N_INPUTS)
) (
  input  logic [N_INPUTS-1:0] i_req,
  input  logic [SEL_W-1:0]    i_ptr,
  output logic [N_INPUTS-1:0] o_grant,
  output logic [SEL_W-1:0]    o_grant_idx,
  output logic                o_any_grant
);
  // Scan from farthest to nearest so the requester closest to i_ptr is written last and wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      if (i_req[wrap_idx(int'(i_ptr), k, N_INPUTS)]) begin
        o_grant = '0;
        o_grant[wrap_idx(int'(i_ptr), k, N_INPUTS)] = 1'b1;
        o_grant_idx = SEL_W'(wrap_idx(int'(i_ptr), k, N_INPUTS));
        o_any_grant = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-input registered valid/ready mux with round-robin arbitration (MUX_RR_ARB_FIXED_PRIO_EN selects fixed lowest-index priority); ports clk, rst, bus (mux_rr_arb_if.slave)
module mux_rr_arb
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_INPUTS   = 4,
  localparam int SEL_W     = sel_width(N_INPUTS)
) (
  input logic         clk,
  input logic         rst,
  mux_rr_arb_if.slave bus
);
  logic [SEL_W-1:0]      w_ptr;
  logic [N_INPUTS-1:0]   w_grant;
  logic [SEL_W-1:0]      w_idx;
  logic                  w_any;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] r_data;
  logic [SEL_W-1:0]      r_sel;
  logic                  r_valid;
`ifdef MUX_RR_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [SEL_W-1:0] r_ptr;
  assign w_ptr = r_ptr;
  always_ff @(posedge clk)
    if (rst) r_ptr <= '0;
    else if (w_load && w_any) r_ptr <= (int'(w_idx) == N_INPUTS - 1) ? '0 : w_idx + 1'b1;
`endif
  rr_arbiter #(.N_INPUTS(N_INPUTS)) u_arb (
    .i_req      (bus.in_valid),
    .i_ptr      (w_ptr),
    .o_grant    (w_grant),
    .o_grant_idx(w_idx),
    .o_any_grant(w_any)
  );
  // The output register can take a word when empty or being drained this cycle.
  assign w_load       = !r_valid || bus.out_ready;
  assign bus.in_ready = (rst || !w_load) ? '0 : w_grant;
  assign bus.out_data  = r_data;
  assign bus.out_sel   = r_sel;
  assign bus.out_valid = r_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_data <= bus.in_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
        r_sel  <= w_idx;
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_arb.sv
// tb_mux_rr_arb: table-driven, scoreboard-checked bench for mux_rr_arb
module tb_mux_rr_arb;
  import mux_pkg::*;
  localparam int DW = 32;
  localparam int N  = 4;
  typedef struct packed {
    logic [N-1:0] v;
    logic         r;
    logic [N-1:0] rdy;
  } vec_t;
  typedef struct packed {
    ch_idx_t       sel;
    logic [DW-1:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mux_rr_arb_if #(.DATA_WIDTH(DW), .N_INPUTS(N)) bus ();
  mux_rr_arb #(.DATA_WIDTH(DW), .N_INPUTS(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  logic [DW-1:0] ch_data [N];
  exp_t q[$];
  vec_t tbl[17];
  int checks = 0;
  int passed = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic drive_data();
    for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = ch_data[i];
  endtask
  // Drive one cycle, check combinational ready and the output register against the scoreboard.
  task automatic step(input logic [N-1:0] v, input logic r, input logic [N-1:0] rdy);
    exp_t e;
    bus.in_valid = v;
    bus.out_ready = r;
    drive_data();
    @(negedge clk);
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_sel", 64'(bus.out_sel), 64'(q[0].sel));
      chk("out_data", 64'(bus.out_data), 64'(q[0].data));
      if (r) void'(q.pop_front());
    end
    for (int i = 0; i < N; i++)
      if (rdy[i]) begin
        e.sel = ch_idx_t'(i);
        e.data = ch_data[i];
        q.push_back(e);
      end
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[5]  = '{4'b0100, 1'b1, 4'b0100};
    tbl[6]  = '{4'b0010, 1'b1, 4'b0010};
    tbl[7]  = '{4'b1000, 1'b1, 4'b1000};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000};
    tbl[10] = '{4'b1111, 1'b0, 4'b0000};
    tbl[11] = '{4'b1111, 1'b0, 4'b0000};
    tbl[12] = '{4'b1111, 1'b0, 4'b0000};
    tbl[13] = '{4'b1111, 1'b0, 4'b0000};
    tbl[14] = '{4'b1111, 1'b1, 4'b0010};
    tbl[15] = '{4'b0000, 1'b1, 4'b0000};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000};
    for (int i = 0; i < N; i++) ch_data[i] = DW'(i * 32'h11);
    rst = 1'b1;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    drive_data();
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_out_data", 64'(bus.out_data), 64'h0);
    chk("rst_out_sel", 64'(bus.out_sel), 64'h0);
`ifdef MUX_RR_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 6; i++) step(4'b1010, 1'b1, 4'b0010);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
`else
    for (int i = 0; i < 17; i++) step(tbl[i].v, tbl[i].r, tbl[i].rdy);
    ch_data[2] = 32'hDEADBEEF;
    step(4'b0100, 1'b1, 4'b0100);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    chk("drain_sel_hold", 64'(bus.out_sel), 64'h2);
    chk("drain_data_hold", 64'(bus.out_data), 64'hDEADBEEF);
    step(4'b1000, 1'b0, 4'b1000);
    rst = 1'b1;
    bus.in_valid = 4'b1111;
    @(negedge clk);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    chk("midrst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("midrst_out_data", 64'(bus.out_data), 64'h0);
    step(4'b1111, 1'b1, 4'b0001);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
`endif
    chk("scoreboard_empty", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
